// File: rtl/uart2wb.sv
// uart2wb: UART command packets in, one Wishbone master cycle per packet, response bytes out
module uart2wb #(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8,
    parameter int clk_per_bit  = 217,
    parameter int byte_timeout = 65535,
    parameter int wb_timeout   = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    uart_rx,
    output logic                    uart_tx,
    output logic [addr_width-1:0]   wb_adr,
    output logic [data_width-1:0]   wb_datwr,
    input  logic [data_width-1:0]   wb_datrd,
    output logic                    wb_we,
    output logic [strobe_width-1:0] wb_sel,
    output logic                    wb_stb,
    output logic                    wb_cyc,
    input  logic                    wb_ack
);
    localparam int AB  = (addr_width + 7) / 8;
    localparam int DB  = data_width / 8;
    localparam int SB  = (strobe_width + 7) / 8;
    localparam int AW8 = AB * 8;
    localparam int SW8 = SB * 8;
    localparam int CW  = $clog2(clk_per_bit + 1);
    localparam int BW  = $clog2(byte_timeout + 1);
    localparam int WW  = $clog2(wb_timeout + 1);
    localparam logic [CW-1:0] HALF   = CW'(clk_per_bit / 2);
    localparam logic [CW-1:0] FULL   = CW'(clk_per_bit - 1);
    localparam logic [BW-1:0] BT     = BW'(byte_timeout);
    localparam logic [WW-1:0] WT     = WW'(wb_timeout);
    localparam logic [7:0]    A_LAST = 8'(AB - 1);
    localparam logic [7:0]    D_LAST = 8'(DB - 1);
    localparam logic [7:0]    S_LAST = 8'(SB - 1);

    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, RX_SEL, WB_REQ, TX_RESP} state_t;

    state_t                  state;
    logic                    rx_s1, rx_s2, rx_busy, byte_valid;
    logic [CW-1:0]           rx_cnt, tx_cnt;
    logic [3:0]              rx_bit, tx_bit;
    logic [7:0]              rx_byte, tx_byte;
    logic [8:0]              tx_sh;
    logic                    tx_busy, tx_load, byte_done;
    logic                    we_l, last, start_bus;
    logic [7:0]              fcnt;
    logic [BW-1:0]           bto;
    logic [WW-1:0]           wto;
    logic [addr_width-1:0]   adr_r, adr_nx;
    logic [data_width-1:0]   dat_r, dat_nx, resp;
    logic [strobe_width-1:0] sel_r, sel_nx;

    // field assembly (bytes beyond the field width fall off) and end-of-field decode
    always_comb begin
        adr_nx    = adr_r | addr_width'(AW8'(rx_byte) << {fcnt, 3'b0});
        dat_nx    = dat_r | (data_width'(rx_byte) << {fcnt, 3'b0});
        sel_nx    = sel_r | strobe_width'(SW8'(rx_byte) << {fcnt, 3'b0});
        last      = fcnt == (state == RX_ADDR ? A_LAST : state == RX_DATA ? D_LAST : S_LAST);
        start_bus = byte_valid && last && ((state == RX_ADDR && !we_l) || state == RX_SEL);
        byte_done = tx_busy && tx_bit == 4'd9 && tx_cnt == '0;
    end

    // receiver: synchronize, find start on low level, sample mid-bit, flag byte at stop sample
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_busy    <= 1'b0;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            byte_valid <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0)
                rx_cnt <= rx_cnt - 1'b1;
            else begin
                rx_cnt <= FULL;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd9) begin
                    rx_busy    <= 1'b0;
                    byte_valid <= 1'b1;
                end else if (rx_bit != 4'd0)
                    rx_byte <= {rx_s2, rx_byte[7:1]};
            end
        end

    // transmitter: start, 8 data bits LSB first, stop; byte_done marks the last stop clock
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '1;
        end else if (tx_load) begin
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
            tx_cnt  <= FULL;
            tx_bit  <= '0;
            tx_sh   <= {1'b1, tx_byte};
        end else if (tx_busy) begin
            if (tx_cnt != '0)
                tx_cnt <= tx_cnt - 1'b1;
            else if (tx_bit == 4'd9)
                tx_busy <= 1'b0;
            else begin
                uart_tx <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_cnt  <= FULL;
                tx_bit  <= tx_bit + 4'd1;
            end
        end

    // packet FSM: collect fields, run the bus cycle, queue the response bytes
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state    <= IDLE;
            we_l     <= 1'b0;
            adr_r    <= '0;
            dat_r    <= '0;
            sel_r    <= '0;
            fcnt     <= '0;
            bto      <= '0;
            wto      <= '0;
            resp     <= '0;
            tx_load  <= 1'b0;
            tx_byte  <= '0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_datwr <= '0;
            wb_sel   <= '0;
        end else begin
            tx_load <= 1'b0;
            case (state)
                IDLE:
                    if (byte_valid && rx_byte[7:1] == 7'd0) begin
                        we_l  <= rx_byte[0];
                        adr_r <= '0;
                        dat_r <= '0;
                        sel_r <= '0;
                        fcnt  <= '0;
                        bto   <= '0;
                        state <= RX_ADDR;
                    end
                RX_ADDR, RX_DATA, RX_SEL: begin
                    if (byte_valid) begin
                        bto   <= '0;
                        fcnt  <= last ? 8'd0 : fcnt + 8'd1;
                        adr_r <= state == RX_ADDR ? adr_nx : adr_r;
                        dat_r <= state == RX_DATA ? dat_nx : dat_r;
                        sel_r <= state == RX_SEL ? sel_nx : sel_r;
                        if (last)
                            state <= state == RX_ADDR ? (we_l ? RX_DATA : WB_REQ) : state == RX_DATA ? RX_SEL : WB_REQ;
                    end else if (bto == BT)
                        state <= IDLE;
                    else
                        bto <= bto + 1'b1;
                    if (start_bus) begin
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        wb_we    <= we_l;
                        wb_adr   <= state == RX_ADDR ? adr_nx : adr_r;
                        wb_sel   <= we_l ? sel_nx : '1;
                        wb_datwr <= we_l ? dat_r : '0;
                        wto      <= '0;
                    end
                end
                WB_REQ:
                    if (wb_ack || wto == WT) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        state   <= TX_RESP;
                        tx_load <= 1'b1;
                        tx_byte <= !wb_ack ? 8'h00 : wb_we ? 8'h01 : wb_datrd[7:0];
                        resp    <= wb_ack && !wb_we ? wb_datrd >> 8 : '0;
                        fcnt    <= wb_we ? 8'd0 : D_LAST;
                    end else
                        wto <= wto + 1'b1;
                TX_RESP:
                    if (byte_done) begin
                        if (fcnt == 8'd0)
                            state <= IDLE;
                        else begin
                            tx_load <= 1'b1;
                            tx_byte <= resp[7:0];
                            resp    <= resp >> 8;
                            fcnt    <= fcnt - 8'd1;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart2wb.sv
// tb_uart2wb: random packets against a queue-based bridge model, plus directed corner cases
module tb_uart2wb;
    localparam int CPB = 8;
    localparam int BTO = 300;
    localparam int WTO = 20;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          lmin;
        int          lmax;
    } bus_t;

    logic        clock, reset, uart_rx, uart_tx;
    logic [31:0] wb_adr, wb_datwr, wb_datrd;
    logic        wb_we, wb_stb, wb_cyc, wb_ack;
    logic [3:0]  wb_sel;

    int          n_chk = 0, n_err = 0;
    bus_t        exp_bus[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  got[$];
    bus_t        cur;
    bit          cur_ok = 0, cyc_prev = 0, tx_act = 0;
    int          cyc_len = 0, last_len = 0, ncyc = 0, tx_ph = 0;
    logic [7:0]  tx_sh;
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we;
    int          sl_wait = 0, sl_cnt = 0;
    bit          sl_nack = 0;

    uart2wb #(.addr_width(32), .data_width(32), .clk_per_bit(CPB), .byte_timeout(BTO), .wb_timeout(WTO)) dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_datrd(wb_datrd), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a == 32'h12345678 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // slave: acks after sl_wait wait states unless sl_nack; read data is junk except on ack
    always @(negedge clock) begin
        if (!reset && wb_cyc && wb_stb) begin
            if (!sl_nack && sl_cnt == sl_wait) begin
                wb_ack   = 1'b1;
                wb_datrd = slave_data(wb_adr);
            end else begin
                wb_ack   = 1'b0;
                wb_datrd = $urandom;
            end
            sl_cnt++;
        end else begin
            wb_ack   = 1'b0;
            wb_datrd = $urandom;
            sl_cnt   = 0;
        end
    end

    // compare: bus cycles and serial response bytes against the expectation queues
    always @(negedge clock) begin
        if (reset) begin
            exp_bus.delete();
            exp_rx.delete();
            tx_act   = 0;
            cyc_prev = 0;
            cur_ok   = 0;
        end else begin
            if (!cyc_prev && exp_bus.size() == 0)
                chk("cyc_idle", wb_cyc, 0);
            if (wb_cyc && !cyc_prev) begin
                ncyc++;
                cyc_len = 0;
                obs_adr = wb_adr; obs_dat = wb_datwr; obs_sel = wb_sel; obs_we = wb_we;
                cur_ok  = exp_bus.size() != 0;
                if (cur_ok) begin
                    cur = exp_bus.pop_front();
                    chk("bus_adr", wb_adr, cur.adr);
                    chk("bus_we", wb_we, cur.we);
                    chk("bus_sel", wb_sel, cur.sel);
                    chk("bus_datwr", wb_datwr, cur.dat);
                    chk("bus_stb", wb_stb, 1);
                end
            end else if (wb_cyc && cur_ok) begin
                chk("hold_adr", wb_adr, cur.adr);
                chk("hold_datwr", wb_datwr, cur.dat);
                chk("hold_we_sel_stb", {wb_we, wb_sel, wb_stb}, {cur.we, cur.sel, 1'b1});
            end else if (!wb_cyc && cyc_prev && cur_ok) begin
                last_len = cyc_len;
                n_chk++;
                if (cyc_len < cur.lmin || cyc_len > cur.lmax) begin
                    n_err++;
                    $display("FAIL cyc_len: got %0d required %0d..%0d", cyc_len, cur.lmin, cur.lmax);
                end
            end
            if (wb_cyc) cyc_len++;
            cyc_prev = wb_cyc;
            if (!tx_act) begin
                if (exp_rx.size() == 0)
                    chk("tx_idle", uart_tx, 1);
                if (uart_tx == 1'b0) begin
                    tx_act = 1;
                    tx_ph  = 0;
                end
            end else begin
                tx_ph++;
                if (tx_ph == 4)
                    chk("tx_start_bit", uart_tx, 0);
                if (tx_ph >= 12 && tx_ph <= 68 && tx_ph % 8 == 4)
                    tx_sh = {uart_tx, tx_sh[7:1]};
                if (tx_ph == 76) begin
                    tx_act = 0;
                    chk("tx_stop_bit", uart_tx, 1);
                    got.push_back(tx_sh);
                    if (exp_rx.size() != 0)
                        chk("tx_byte", tx_sh, exp_rx.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = 1'b1;
        repeat (CPB + gap) @(negedge clock);
    endtask

    // model: a packet yields exactly one bus cycle and a known response byte list
    task automatic send_pkt(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [7:0] sel8, input int waits, input bit nack, input int gap);
        bus_t b;
        b.adr  = adr;
        b.we   = we;
        b.sel  = we ? sel8[3:0] : 4'hF;
        b.dat  = we ? dat : 32'h0;
        b.lmin = nack ? WTO : waits + 1;
        b.lmax = nack ? WTO + 1 : waits + 1;
        exp_bus.push_back(b);
        for (int i = 0; i < (we ? 1 : 4); i++)
            exp_rx.push_back(nack ? 8'h00 : we ? 8'h01 : 8'(slave_data(adr) >> (8 * i)));
        sl_wait = waits;
        sl_nack = nack;
        send_byte({7'd0, we}, gap);
        for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8], gap);
        if (we) begin
            for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8], gap);
            send_byte(sel8, gap);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_rx.size() != 0 || exp_bus.size() != 0 || tx_act || wb_cyc) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("done_within_budget", n < 3000, 1);
        repeat (20) @(negedge clock);
    endtask

    initial begin
        int c0, g0, n;
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_datwr", wb_datwr, 0);
        chk("rst_sel", wb_sel, 0);
        #2 reset = 1'b0;
        repeat (5) @(negedge clock);

        send_pkt(0, 32'h12345678, 0, 0, 2, 0, 0);
        wait_done();
        g0 = got.size();
        chk("read_resp", {got[g0-4], got[g0-3], got[g0-2], got[g0-1]}, 32'hEFBEADDE);
        chk("read_len", last_len, 3);
        chk("read_adr", obs_adr, 32'h12345678);

        send_pkt(1, 32'h10, 32'h11223344, 8'h05, 0, 0, 0);
        wait_done();
        chk("write_adr", obs_adr, 32'h10);
        chk("write_dat", obs_dat, 32'h11223344);
        chk("write_sel_we", {obs_sel, obs_we}, {4'h5, 1'b1});
        chk("write_len", last_len, 1);
        chk("write_resp", got[got.size()-1], 8'h01);

        send_pkt(1, 32'h44, 32'hA5A5A5A5, 8'hF6, 1, 0, 3);
        wait_done();
        chk("sel_drop", obs_sel, 4'h6);

        c0 = ncyc;
        send_byte(8'h80, 0);
        send_pkt(0, 32'h4, 0, 0, 1, 0, 0);
        wait_done();
        chk("badcmd_cycles", ncyc - c0, 1);
        chk("badcmd_adr", obs_adr, 32'h4);

        c0 = ncyc;
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        repeat (BTO + 10) @(negedge clock);
        send_pkt(0, 32'h20, 0, 0, 0, 0, 0);
        wait_done();
        chk("bto_cycles", ncyc - c0, 1);
        chk("bto_adr", obs_adr, 32'h20);

        send_pkt(0, 32'h300, 0, 0, 0, 1, 0);
        wait_done();
        g0 = got.size();
        chk("wto_read_resp", {got[g0-4], got[g0-3], got[g0-2], got[g0-1]}, 32'h0);
        send_pkt(1, 32'h304, 32'h1, 8'h0F, 0, 1, 0);
        wait_done();
        chk("wto_write_resp", got[got.size()-1], 8'h00);

        g0 = got.size();
        send_pkt(0, 32'hCAFE0000, 0, 0, 0, 0, 0);
        n = 0;
        while (got.size() < g0 + 1 && n < 3000) begin @(negedge clock); n++; end
        chk("first_byte_seen", n < 3000, 1);
        n = 0;
        while (!tx_act && n < 200) begin @(negedge clock); n++; end
        chk("second_byte_started", n < 200, 1);
        repeat (20) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midrst_uart_tx", uart_tx, 1);
        chk("midrst_cyc", wb_cyc, 0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        send_pkt(1, 32'h40, 32'h55AA00FF, 8'h0C, 1, 0, 0);
        wait_done();
        chk("post_rst_bytes", got.size(), g0 + 2);
        chk("post_rst_resp", got[got.size()-1], 8'h01);

        for (int k = 0; k < 24; k++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) send_byte(8'($urandom_range(2, 255)), $urandom_range(0, 10));
            if (r == 1) begin
                int nb = $urandom_range(0, 3);
                send_byte({7'd0, 1'($urandom_range(0, 1))}, 0);
                for (int i = 0; i < nb; i++) send_byte(8'($urandom), $urandom_range(0, 10));
                repeat (BTO + 20) @(negedge clock);
            end
            send_pkt(1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 20));
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart2wb.md
# uart2wb

Remote end of the serial Wishbone bridge. Receives command packets on a UART line, runs one Wishbone master cycle per packet, and returns the response bytes on its UART transmit line. It sits downstream of the Wishbone-to-UART bridge and drives the target-side bus: memory, peripherals or the register file under test.

## Interface
- `addr_width`, 32: Wishbone address width.
- `data_width`, 32: Wishbone data width, a multiple of 8.
- `strobe_width`, `data_width/8`: width of `wb_sel`.
- `clk_per_bit`, 217: clocks per UART bit (115200 baud at 25 MHz).
- `byte_timeout`, 65535: maximum idle clocks between bytes of one packet.
- `wb_timeout`, 255: maximum clocks to wait for `wb_ack`.
- Derived: `AB = ceil(addr_width/8)`, `DB = data_width/8`, `SB = ceil(strobe_width/8)`.

Ports:
- `clock`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high.
- `uart_rx`  in  1  serial input, 8N1, LSB first.
- `uart_tx`  out  1  serial output, 8N1, LSB first.
- `wb_adr`  out  addr_width  bus address.
- `wb_datwr`  out  data_width  write data.
- `wb_datrd`  in  data_width  read data.
- `wb_we`  out  1  write enable.
- `wb_sel`  out  strobe_width  byte selects.
- `wb_stb`  out  1  strobe.
- `wb_cyc`  out  1  cycle.
- `wb_ack`  in  1  slave acknowledge.

## Operation
- Packet format, all fields LSB byte first:
  - Byte 0 is the command, `{7'd0, we}`.
  - Then `AB` address bytes.
  - For a write only: `DB` data bytes, then `SB` select bytes.
- Response:
  - Read: `DB` bytes of `wb_datrd`, LSB first.
  - Write: one byte, 0x01.
  - Wishbone timeout: the same byte count, all 0x00.
- Receive engine:
  - 2-flop synchronizer on `uart_rx`.
  - Start bit detected on a low level, data sampled at mid-bit, stop bit not checked.
  - Produces a one-cycle `byte_valid`.
- Transmit engine:
  - Loads one byte, then sends start, 8 data and stop bits, `clk_per_bit` clocks each.
  - Pulses `byte_done` at the end of the stop bit.
- FSM states: IDLE, RX_ADDR, RX_DATA, RX_SEL, WB_REQ, TX_RESP.
  - IDLE: a byte with bits[7:1] == 0 latches `we` and moves to RX_ADDR. Any other byte is discarded and the FSM stays in IDLE.
  - RX_ADDR, RX_DATA, RX_SEL: each shifts received bytes into its field and moves on after the last byte.
    - RX_ADDR goes to RX_DATA for a write, WB_REQ for a read.
    - RX_DATA goes to RX_SEL.
    - RX_SEL goes to WB_REQ.
  - WB_REQ: `cyc`/`stb` held high until `wb_ack` is sampled or `wb_timeout` clocks elapse, then go to TX_RESP.
  - TX_RESP: sends the response bytes back to back, then returns to IDLE.
- Address bits above `addr_width` are dropped. Select bits above `strobe_width` are dropped.
- Reads drive `wb_sel` all ones and `wb_datwr` 0.
- Bytes arriving outside the IDLE and RX_* states are discarded.

## Timing
- Reset values: `uart_tx`=1, `wb_cyc`=`wb_stb`=`wb_we`=0, `wb_adr`=0, `wb_datwr`=0, `wb_sel`=0. FSM in IDLE, all counters 0.
- Reset mid-packet, mid-bus-cycle or mid-transmit aborts immediately, with no partial byte or response emitted afterwards.
- All Wishbone outputs are registered.
- Starting the bus cycle: on the edge that captures the last packet byte, the FSM enters WB_REQ and `wb_cyc`/`wb_stb` rise, so the bus sees them one clock after `byte_valid`.
- `wb_adr`/`wb_we`/`wb_sel`/`wb_datwr` are stable from that edge until `cyc` falls.
- Ending the bus cycle:
  - On the edge where `wb_ack`=1 is sampled, `cyc`/`stb` fall and `wb_datrd` is latched.
  - An ack present on the first WB_REQ cycle gives a one-cycle bus cycle.
- Wishbone timeout: the counter starts at WB_REQ entry. When it reaches `wb_timeout` with no ack, `cyc`/`stb` fall and the response is zeros. A late `wb_ack` is ignored.
- Byte timeout:
  - The counter clears on every `byte_valid` in RX_* states.
  - Reaching `byte_timeout` returns the FSM to IDLE, discarding the partial packet.
  - A `byte_valid` in the same cycle as the timeout wins, so the byte is accepted.
- Transmit pacing:
  - The first response byte loads the cycle after TX_RESP entry.
  - Each next byte loads the cycle after `byte_done`, so the inter-byte gap is 1 clock.
  - IDLE is entered the cycle after the last `byte_done`.
- Latency from the last received stop-bit sample to the first transmitted start bit is 3 clocks plus the bus wait.

## Test plan
Bench settings: `clk_per_bit`=8, `addr_width`=`data_width`=32.
- Read: send 00 78 56 34 12; slave acks with 0xDEADBEEF after 2 wait states -> one cycle with `wb_adr`=0x12345678, `we`=0, `sel`=0xF; `uart_tx` sends EF BE AD DE.
- Write: send 01 10 00 00 00 44 33 22 11 05 -> `wb_adr`=0x10, `wb_datwr`=0x11223344, `sel`=0x5, `we`=1; same-cycle ack -> `cyc` high exactly 1 clock; response 01.
- Bad command: send 80 then a valid read of 0x4 -> no bus cycle for 0x80; the read completes with correct data.
- Byte timeout: send 00 11, wait `byte_timeout`+10 clocks, then a read of 0x20 -> single bus cycle at 0x20.
- Wishbone timeout: read with a never-acking slave -> `cyc` falls after `wb_timeout` clocks; response 00 00 00 00. Same case for a write -> response 00.
- Reset mid-response: assert `reset` during the second response byte -> `uart_tx`=1 and `cyc`=0 immediately; a following write completes normally.
